// File: rtl/timer_irq_sched.sv
// timer_irq_sched: four-channel tick-driven alarm scheduler with one shared irq line.
// Channels count down on each tick, set a pending flag on expiry, and reload (periodic) or stop (oneshot).
// Optional macro TIMER_SCHED_READ_LATCH_EN: a low-byte count read snapshots the high byte so that
// a following high-byte read is coherent across ticks.
module timer_irq_sched #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       cs,
  input  logic       rwb,
  input  logic [3:0] addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       irq
);

  localparam logic [3:0] CH_MASK = 4'((1 << NUM_CH) - 1);
  localparam logic [3:0] A_CTRL  = 4'd8;
  localparam logic [3:0] A_STAT  = 4'd9;
  localparam logic [3:0] A_MASK  = 4'd10;
  localparam logic [3:0] A_VEC   = 4'd11;

  logic [CNT_W-1:0] count  [NUM_CH];
  logic [CNT_W-1:0] reload [NUM_CH];
  logic [7:0]       stage  [NUM_CH];
  logic [3:0]       enable;
  logic [3:0]       oneshot;
  logic [3:0]       pending;
  logic [3:0]       mask;
  logic             wr;
  logic [3:0]       arm;
  logic [3:0]       expire;
  logic [3:0]       clr;
  logic [3:0]       active;
  logic [7:0]       vector;

  assign wr  = cs & ~rwb;
  assign clr = (wr && addr == A_STAT) ? i_data[3:0] : 4'b0000;

  // Per-channel arm strobes and expiry events; an arm on the same edge suppresses that tick.
  always_comb begin
    arm    = '0;
    expire = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      arm[n]    = wr && (addr == 4'(2 * n));
      expire[n] = tick && enable[n] && !arm[n] && (count[n] == CNT_W'(1));
    end
  end

  // Lowest-numbered pending-and-unmasked channel wins the vector.
  always_comb begin
    active = pending & mask;
    vector = '0;
    for (int n = 3; n >= 0; n--) begin
      if (active[n]) vector = {1'b1, 5'b00000, 2'(n)};
    end
  end

  // Counters, reloads, staging bytes, control, status, mask and registered irq.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        count[n]  <= '0;
        reload[n] <= '0;
        stage[n]  <= '0;
      end
      enable  <= '0;
      oneshot <= '0;
      pending <= '0;
      mask    <= '0;
      irq     <= 1'b0;
    end else begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        if (arm[n]) begin
          count[n]  <= CNT_W'({stage[n], i_data});
          reload[n] <= CNT_W'({stage[n], i_data});
        end else if (tick && enable[n] && count[n] != '0) begin
          if (count[n] == CNT_W'(1)) count[n] <= oneshot[n] ? '0 : reload[n];
          else                       count[n] <= count[n] - CNT_W'(1);
        end
        if (wr && addr == 4'(2 * n + 1)) stage[n] <= i_data;
      end

      if (wr && addr == A_CTRL) begin
        enable  <= i_data[3:0] & CH_MASK;
        oneshot <= i_data[7:4] & CH_MASK;
      end else begin
        enable  <= (enable & ~(expire & oneshot)) | arm;
      end

      pending <= ((pending & ~clr) | expire) & CH_MASK;

      if (wr && addr == A_MASK) mask <= i_data[3:0] & CH_MASK;

      irq <= |active;
    end
  end

`ifdef TIMER_SCHED_READ_LATCH_EN
  logic       rd;
  logic [7:0] shadow [NUM_CH];

  assign rd = cs & rwb;

  // Snapshot the high byte whenever the matching low byte is read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < int'(NUM_CH); n++) shadow[n] <= '0;
    end else begin
      for (int n = 0; n < int'(NUM_CH); n++) begin
        if (rd && addr == 4'(2 * n)) shadow[n] <= count[n][15:8];
      end
    end
  end
`endif

  // Combinational read mux; absent channels and reserved addresses read 0.
  always_comb begin
    o_data = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      if (addr == 4'(2 * n)) o_data = count[n][7:0];
`ifdef TIMER_SCHED_READ_LATCH_EN
      if (addr == 4'(2 * n + 1)) o_data = shadow[n];
`else
      if (addr == 4'(2 * n + 1)) o_data = count[n][15:8];
`endif
    end
    case (addr)
      A_CTRL:  o_data = {oneshot, enable};
      A_STAT:  o_data = {4'b0000, pending};
      A_MASK:  o_data = {4'b0000, mask};
      A_VEC:   o_data = vector;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_sched.sv
// tb_timer_irq_sched: directed vector table plus hand-written corner sequences for timer_irq_sched.
module tb_timer_irq_sched;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       cs;
  logic       rwb;
  logic [3:0] addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       irq;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         wr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    bit         tk;
    logic [3:0] raddr;
    logic [7:0] exp_data;
    bit         exp_irq;
  } vec_t;

  vec_t v[$];

  timer_irq_sched dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .cs     (cs),
    .rwb    (rwb),
    .addr   (addr),
    .i_data (i_data),
    .o_data (o_data),
    .irq    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(bit wr, logic [3:0] wa, logic [7:0] wd, bit tk,
                              logic [3:0] ra, logic [7:0] ed, bit ei);
    vec_t r;
    r.wr = wr; r.waddr = wa; r.wdata = wd; r.tk = tk;
    r.raddr = ra; r.exp_data = ed; r.exp_irq = ei;
    return r;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One bus cycle across a rising edge, then return the bus to idle.
  task automatic cyc(bit c, bit r, logic [3:0] a, logic [7:0] d, bit t);
    cs = c; rwb = r; addr = a; i_data = d; tick = t;
    @(posedge clk); #1;
    cs = 1'b0; rwb = 1'b1; tick = 1'b0;
  endtask

  task automatic peek(string name, logic [3:0] a, logic [7:0] exp);
    addr = a; #1;
    check(name, o_data, exp);
  endtask

  initial begin
    // --- sequence 1: periodic ch0 = 3, mask 0x01
    v.push_back(mk(1, 4'd1,  8'h00, 0, 4'd0,  8'h00, 0));
    v.push_back(mk(1, 4'd0,  8'h03, 0, 4'd0,  8'h03, 0));
    v.push_back(mk(1, 4'd10, 8'h01, 0, 4'd10, 8'h01, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h02, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h01, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd9,  8'h01, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd11, 8'h80, 1));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd0,  8'h03, 1));
    v.push_back(mk(1, 4'd9,  8'h01, 0, 4'd9,  8'h00, 1));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd11, 8'h00, 0));
    // --- sequence 2: oneshot ch0, five extra ticks after clearing
    v.push_back(mk(1, 4'd8,  8'h11, 0, 4'd8,  8'h11, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h02, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h01, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h00, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd8,  8'h10, 1));
    v.push_back(mk(1, 4'd9,  8'h01, 0, 4'd9,  8'h00, 1));
    for (int k = 0; k < 5; k++) v.push_back(mk(0, 4'd0, 8'h00, 1, 4'd9, 8'h00, 0));
    // --- sequence 3: ch1 = ch2 = 2 periodic, mask 0x06, priority between them
    v.push_back(mk(1, 4'd3,  8'h00, 0, 4'd2,  8'h00, 0));
    v.push_back(mk(1, 4'd2,  8'h02, 0, 4'd8,  8'h12, 0));
    v.push_back(mk(1, 4'd5,  8'h00, 0, 4'd4,  8'h00, 0));
    v.push_back(mk(1, 4'd4,  8'h02, 0, 4'd8,  8'h16, 0));
    v.push_back(mk(1, 4'd10, 8'h06, 0, 4'd10, 8'h06, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd2,  8'h01, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd9,  8'h06, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd11, 8'h81, 1));
    v.push_back(mk(1, 4'd9,  8'h02, 0, 4'd11, 8'h82, 1));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd2,  8'h02, 1));
    v.push_back(mk(1, 4'd9,  8'h04, 0, 4'd9,  8'h00, 1));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd11, 8'h00, 0));
    // --- same-edge events: arm vs tick, set vs clear, control write vs auto-disable
    v.push_back(mk(1, 4'd8,  8'h00, 0, 4'd8,  8'h00, 0));
    v.push_back(mk(1, 4'd10, 8'h01, 0, 4'd10, 8'h01, 0));
    v.push_back(mk(1, 4'd0,  8'h02, 1, 4'd0,  8'h02, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h01, 0));
    v.push_back(mk(1, 4'd9,  8'h01, 1, 4'd9,  8'h01, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd11, 8'h80, 1));
    v.push_back(mk(1, 4'd9,  8'h01, 0, 4'd9,  8'h00, 1));
    v.push_back(mk(1, 4'd8,  8'h11, 0, 4'd8,  8'h11, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 1, 4'd0,  8'h01, 0));
    v.push_back(mk(1, 4'd8,  8'h11, 1, 4'd8,  8'h11, 0));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd0,  8'h00, 1));
    v.push_back(mk(1, 4'd9,  8'h01, 0, 4'd9,  8'h00, 1));
    v.push_back(mk(0, 4'd0,  8'h00, 0, 4'd9,  8'h00, 0));

    reset = 1'b0; tick = 1'b0; cs = 1'b0; rwb = 1'b1; addr = '0; i_data = '0;
    #2;
    check("rst_irq", {7'b0, irq}, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int a = 0; a < 16; a++) peek($sformatf("rst_reg%0d", a), 4'(a), 8'h00);
    check("rst_irq_rel", {7'b0, irq}, 8'h00);

    for (int i = 0; i < v.size(); i++) begin
      cs = v[i].wr; rwb = ~v[i].wr; addr = v[i].waddr; i_data = v[i].wdata; tick = v[i].tk;
      @(posedge clk); #1;
      cs = 1'b0; rwb = 1'b1; tick = 1'b0; addr = v[i].raddr; #1;
      check($sformatf("vec%0d_data", i), o_data, v[i].exp_data);
      check($sformatf("vec%0d_irq", i), {7'b0, irq}, {7'b0, v[i].exp_irq});
    end

    // --- read coherency on ch3
    cyc(1, 0, 4'd7, 8'h01, 0);
    cyc(1, 0, 4'd6, 8'h00, 0);
    cyc(0, 1, 4'd0, 8'h00, 1);
    cs = 1'b1; rwb = 1'b1; addr = 4'd6; #1;
    check("ch3_lo_ff", o_data, 8'hFF);
    @(posedge clk); #1;
    cs = 1'b0;
    cyc(0, 1, 4'd0, 8'h00, 1);
    peek("ch3_hi_a", 4'd7, 8'h00);
    peek("ch3_lo_fe", 4'd6, 8'hFE);
    cyc(1, 0, 4'd6, 8'h00, 0);
    cs = 1'b1; rwb = 1'b1; addr = 4'd6; #1;
    check("ch3_lo_00", o_data, 8'h00);
    @(posedge clk); #1;
    cs = 1'b0;
    cyc(0, 1, 4'd0, 8'h00, 1);
`ifdef TIMER_SCHED_READ_LATCH_EN
    peek("ch3_hi_latched", 4'd7, 8'h01);
`else
    peek("ch3_hi_live", 4'd7, 8'h00);
`endif
    peek("ch3_lo_ff2", 4'd6, 8'hFF);

    // --- reset in the middle of a countdown with irq high
    cyc(1, 0, 4'd8, 8'h08, 0);
    cyc(1, 0, 4'd1, 8'h00, 0);
    cyc(1, 0, 4'd0, 8'h01, 0);
    cyc(0, 1, 4'd0, 8'h00, 1);
    cyc(0, 1, 4'd0, 8'h00, 0);
    check("pre_rst_irq", {7'b0, irq}, 8'h01);
    cyc(1, 0, 4'd0, 8'h03, 0);
    cyc(0, 1, 4'd0, 8'h00, 1);
    peek("pre_rst_cnt0", 4'd0, 8'h02);
    reset = 1'b0; #2;
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
    for (int a = 0; a < 16; a++) peek($sformatf("mid_rst_reg%0d", a), 4'(a), 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) cyc(0, 1, 4'd0, 8'h00, 1);
    check("post_rst_irq", {7'b0, irq}, 8'h00);
    peek("post_rst_stat", 4'd9, 8'h00);
    peek("post_rst_cnt3", 4'd6, 8'h00);
    peek("post_rst_ctrl", 4'd8, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
